cmd_slave_regs: RTL and testbench

Generic register-bank slave on one `intf_cmd` port of the command master. It decodes single-word read/write commands into control registers, status inputs, an ID word and a sticky interrupt block, and acks every access within a fixed two-cycle latency. One instance sits behind each master slave index that needs a plain register map.

---
 rtl/cmd_slave_regs_pkg.sv | 22 ++
 rtl/cmd_slave_regs_if.sv | 16 +
 rtl/cmd_slave_irq_ctrl.sv | 40 ++++
 rtl/cmd_slave_regs.sv | 164 ++++++++++++++++
 tb/tb_cmd_slave_regs.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/cmd_slave_regs_pkg.sv
// Shared constants and types for the cmd_slave_regs register slave.
// Address offsets are byte offsets within the 1 KiB window decoded from byte_addr[9:0].
package cmd_slave_regs_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OFF_BITS = 10;

  localparam logic [OFF_BITS-1:0] CTRL_BASE   = 10'h000;
  localparam logic [OFF_BITS-1:0] STATUS_BASE = 10'h100;
  localparam logic [OFF_BITS-1:0] IRQ_PEND    = 10'h200;
  localparam logic [OFF_BITS-1:0] IRQ_MASK    = 10'h204;
  localparam logic [OFF_BITS-1:0] ID_OFFSET   = 10'h208;

  localparam logic [DATA_W-1:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESPOND
  } state_e;

endpackage

// File: rtl/cmd_slave_regs_if.sv
// Single-word command port between the command master and one register slave.
interface intf_cmd
  import cmd_slave_regs_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 24
);
  logic                 sel;
  logic                 rd_wr_n;
  logic [ADDR_BITS-1:0] byte_addr;
  logic [DATA_W-1:0]    wdata;
  logic [DATA_W-1:0]    rdata;
  logic                 ack;

  modport master (output sel, rd_wr_n, byte_addr, wdata, input rdata, ack);
  modport slave  (input sel, rd_wr_n, byte_addr, wdata, output rdata, ack);
endinterface

// File: rtl/cmd_slave_irq_ctrl.sv
// Sticky interrupt pending bits with W1C clear (set wins), mask register and registered IRQ.
module cmd_slave_irq_ctrl #(
  parameter int unsigned IRQ_BITS = 16
) (
  input  logic                i_sysclk,
  input  logic                i_arst,
  input  logic [IRQ_BITS-1:0] i_irq_set,
  input  logic [IRQ_BITS-1:0] i_clr,
  input  logic                i_mask_we,
  input  logic [IRQ_BITS-1:0] i_mask_wdata,
  output logic [IRQ_BITS-1:0] o_pending,
  output logic [IRQ_BITS-1:0] o_mask,
  output logic                o_irq
);
  logic [IRQ_BITS-1:0] pend_q, pend_d;
  logic [IRQ_BITS-1:0] mask_q, mask_d;
  logic                irq_q, irq_d;

  always_comb begin
    pend_d = (pend_q & ~i_clr) | i_irq_set;
    mask_d = i_mask_we ? i_mask_wdata : mask_q;
    irq_d  = |(pend_q & mask_q);
  end

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      pend_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign o_pending = pend_q;
  assign o_mask    = mask_q;
  assign o_irq     = irq_q;
endmodule

// File: rtl/cmd_slave_regs.sv
// Register-bank slave: control, status, ID and (with CMD_SLAVE_REGS_IRQ_EN) interrupt registers.
// Every command is acked two cycles after sel via IDLE -> ACCESS -> RESPOND.
module cmd_slave_regs
  import cmd_slave_regs_pkg::*;
#(
  parameter int unsigned CMD_ADDR_BITS = 24,
  parameter int unsigned NUM_CTRL      = 8,
  parameter int unsigned NUM_STATUS    = 8,
  parameter int unsigned IRQ_BITS      = 16,
  parameter logic [31:0] BLOCK_ID      = 32'h0000_0000
) (
  input  logic                             i_sysclk,
  input  logic                             i_arst,
  intf_cmd.slave                           cmd,
  output logic [NUM_CTRL-1:0][DATA_W-1:0]  o_ctrl,
  output logic [NUM_CTRL-1:0]              o_ctrl_wstb,
  input  logic [NUM_STATUS-1:0][DATA_W-1:0] i_status,
  input  logic [IRQ_BITS-1:0]              i_irq_set,
  output logic                             o_irq
);
  state_e state_q, state_d;

  logic              rw_q;
  logic [7:0]        woff_q;
  logic [DATA_W-1:0] wdata_q;
  logic              latch_cmd;

  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_CTRL-1:0][DATA_W-1:0] ctrl_q, ctrl_d;
  logic [NUM_CTRL-1:0] wstb_q, wstb_d;

  logic              is_ctrl, is_status;
  logic [5:0]        reg_idx;
  logic [DATA_W-1:0] rd_val;

`ifdef CMD_SLAVE_REGS_IRQ_EN
  logic [IRQ_BITS-1:0] irq_pend, irq_mask, irq_clr;
  logic                irq_mask_we;
`endif

  // Address decode and read mux from the registered word offset.
  always_comb begin
    is_ctrl   = (woff_q[7:6] == CTRL_BASE[9:8]);
    is_status = (woff_q[7:6] == STATUS_BASE[9:8]);
    reg_idx   = woff_q[5:0];
    rd_val    = UNMAPPED_RDATA;
    for (int unsigned k = 0; k < NUM_CTRL; k++) begin
      if (is_ctrl && reg_idx == 6'(k)) rd_val = ctrl_q[k];
    end
    for (int unsigned k = 0; k < NUM_STATUS; k++) begin
      if (is_status && reg_idx == 6'(k)) rd_val = i_status[k];
    end
    if (woff_q == ID_OFFSET[9:2]) rd_val = BLOCK_ID;
`ifdef CMD_SLAVE_REGS_IRQ_EN
    if (woff_q == IRQ_PEND[9:2]) rd_val = 32'(irq_pend);
    if (woff_q == IRQ_MASK[9:2]) rd_val = 32'(irq_mask);
`endif
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d   = state_q;
    latch_cmd = 1'b0;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    ctrl_d    = ctrl_q;
    wstb_d    = '0;
`ifdef CMD_SLAVE_REGS_IRQ_EN
    irq_clr     = '0;
    irq_mask_we = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cmd.sel) begin
          latch_cmd = 1'b1;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESPOND;
        ack_d   = 1'b1;
        rdata_d = rd_val;
        if (!rw_q) begin
          for (int unsigned k = 0; k < NUM_CTRL; k++) begin
            if (is_ctrl && reg_idx == 6'(k)) begin
              ctrl_d[k] = wdata_q;
              wstb_d[k] = 1'b1;
            end
          end
`ifdef CMD_SLAVE_REGS_IRQ_EN
          if (woff_q == IRQ_PEND[9:2]) irq_clr = wdata_q[IRQ_BITS-1:0];
          if (woff_q == IRQ_MASK[9:2]) irq_mask_we = 1'b1;
`endif
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      ctrl_q  <= '0;
      wstb_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      ctrl_q  <= ctrl_d;
      wstb_q  <= wstb_d;
    end
  end

  // Command capture in the IDLE cycle that sees sel.
  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      rw_q    <= 1'b1;
      woff_q  <= '0;
      wdata_q <= '0;
    end else if (latch_cmd) begin
      rw_q    <= cmd.rd_wr_n;
      woff_q  <= cmd.byte_addr[9:2];
      wdata_q <= cmd.wdata;
    end
  end

`ifdef CMD_SLAVE_REGS_IRQ_EN
  cmd_slave_irq_ctrl #(
    .IRQ_BITS (IRQ_BITS)
  ) u_irq (
    .i_sysclk     (i_sysclk),
    .i_arst       (i_arst),
    .i_irq_set    (i_irq_set),
    .i_clr        (irq_clr),
    .i_mask_we    (irq_mask_we),
    .i_mask_wdata (wdata_q[IRQ_BITS-1:0]),
    .o_pending    (irq_pend),
    .o_mask       (irq_mask),
    .o_irq        (o_irq)
  );
`else
  assign o_irq = 1'b0;
`endif

  // Ignored address bits (and irq inputs when interrupts are compiled out).
  logic unused_bits;
`ifdef CMD_SLAVE_REGS_IRQ_EN
  assign unused_bits = ^{cmd.byte_addr[CMD_ADDR_BITS-1:10], cmd.byte_addr[1:0]};
`else
  assign unused_bits = ^{cmd.byte_addr[CMD_ADDR_BITS-1:10], cmd.byte_addr[1:0], i_irq_set};
`endif

  assign cmd.ack     = ack_q;
  assign cmd.rdata   = rdata_q;
  assign o_ctrl      = ctrl_q;
  assign o_ctrl_wstb = wstb_q;

  sel_only_in_idle: assert property (@(posedge i_sysclk) disable iff (i_arst)
    (state_q != ST_IDLE) |-> !cmd.sel);
endmodule

// File: tb/tb_cmd_slave_regs.sv
// Directed bench for cmd_slave_regs with a read-data scoreboard and latency checks.
module tb_cmd_slave_regs;
  import cmd_slave_regs_pkg::*;

  localparam logic [31:0] TB_ID = 32'hC0DE_0001;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [7:0][31:0] o_ctrl;
  logic [7:0]       o_ctrl_wstb;
  logic [7:0][31:0] i_status = '0;
  logic [15:0]      i_irq_set = '0;
  logic             o_irq;

  intf_cmd #(.ADDR_BITS(24)) cmd_if ();

  cmd_slave_regs #(
    .CMD_ADDR_BITS (24),
    .NUM_CTRL      (8),
    .NUM_STATUS    (8),
    .IRQ_BITS      (16),
    .BLOCK_ID      (TB_ID)
  ) dut (
    .i_sysclk    (clk),
    .i_arst      (arst),
    .cmd         (cmd_if.slave),
    .o_ctrl      (o_ctrl),
    .o_ctrl_wstb (o_ctrl_wstb),
    .i_status    (i_status),
    .i_irq_set   (i_irq_set),
    .o_irq       (o_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  wstb_at_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command: sel for one cycle, bounded wait for ack, scoreboard compare.
  task automatic access(input logic rw, input logic [23:0] a, input logic [31:0] wd,
                        input logic chk, input logic [31:0] exp, input logic [15:0] irq_acc);
    int   n;
    logic seen;
    exp_t e;
    sb_q.push_back('{chk: chk, val: exp});
    @(negedge clk);
    cmd_if.sel = 1'b1; cmd_if.rd_wr_n = rw; cmd_if.byte_addr = a; cmd_if.wdata = wd;
    @(negedge clk);
    cmd_if.sel = 1'b0; i_irq_set = irq_acc;
    n = 1; seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      i_irq_set = '0;
      n++;
      if (cmd_if.ack === 1'b1) seen = 1'b1;
    end
    wstb_at_ack = o_ctrl_wstb;
    check("ack_seen", 32'(seen), 32'd1);
    check("ack_latency", 32'(n), 32'd2);
    e = sb_q.pop_front();
    if (seen && e.chk) check("rdata", cmd_if.rdata, e.val);
    @(negedge clk);
    check("ack_one_cycle", 32'(cmd_if.ack), 32'd0);
    check("wstb_after", 32'(o_ctrl_wstb), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_if.sel = 1'b0; cmd_if.rd_wr_n = 1'b1; cmd_if.byte_addr = '0; cmd_if.wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(cmd_if.ack), 32'd0);
    check("rst_rdata", cmd_if.rdata, 32'd0);
    check("rst_ctrl0", o_ctrl[0], 32'd0);
    check("rst_wstb", 32'(o_ctrl_wstb), 32'd0);
    check("rst_irq", 32'(o_irq), 32'd0);
    arst = 1'b0;

    // ctrl write then readback, with ignored upper and low address bits
    access(1'b0, 24'h000004, 32'hA5A5_0001, 1'b0, 32'h0, '0);
    check("wstb_at_ack", 32'(wstb_at_ack), 32'h0000_0002);
    check("ctrl1", o_ctrl[1], 32'hA5A5_0001);
    access(1'b1, 24'h000004, 32'h0, 1'b1, 32'hA5A5_0001, '0);
    access(1'b1, 24'hABC007, 32'h0, 1'b1, 32'hA5A5_0001, '0);
    access(1'b0, 24'h00001C, 32'h0000_7777, 1'b0, 32'h0, '0);
    check("wstb_ctrl7", 32'(wstb_at_ack), 32'h0000_0080);
    access(1'b1, 24'h00001C, 32'h0, 1'b1, 32'h0000_7777, '0);

    // ctrl index beyond NUM_CTRL is unmapped
    access(1'b0, 24'h000020, 32'h1111_1111, 1'b0, 32'h0, '0);
    check("wstb_unmapped", 32'(wstb_at_ack), 32'h0);
    access(1'b1, 24'h000020, 32'h0, 1'b1, UNMAPPED_RDATA, '0);

    // status read, write ignored
    i_status[3] = 32'h1234_5678;
    access(1'b1, 24'h00010C, 32'h0, 1'b1, 32'h1234_5678, '0);
    access(1'b0, 24'h00010C, 32'h0, 1'b0, 32'h0, '0);
    check("wstb_status_wr", 32'(wstb_at_ack), 32'h0);
    check("ctrl1_kept", o_ctrl[1], 32'hA5A5_0001);
    access(1'b1, 24'h00010C, 32'h0, 1'b1, 32'h1234_5678, '0);
    access(1'b1, 24'h000120, 32'h0, 1'b1, UNMAPPED_RDATA, '0);

    // unmapped and ID
    access(1'b1, 24'h0003FC, 32'h0, 1'b1, UNMAPPED_RDATA, '0);
    access(1'b1, 24'h000208, 32'h0, 1'b1, TB_ID, '0);
    access(1'b0, 24'h000208, 32'hFFFF_FFFF, 1'b0, 32'h0, '0);
    access(1'b1, 24'h000208, 32'h0, 1'b1, TB_ID, '0);

`ifdef CMD_SLAVE_REGS_IRQ_EN
    @(negedge clk); i_irq_set = 16'h0004;
    @(negedge clk); i_irq_set = '0;
    repeat (2) @(negedge clk);
    access(1'b1, 24'h000200, 32'h0, 1'b1, 32'h0000_0004, '0);
    check("irq_masked", 32'(o_irq), 32'd0);
    access(1'b0, 24'h000204, 32'hFFFF_0004, 1'b0, 32'h0, '0);
    check("irq_unmasked", 32'(o_irq), 32'd1);
    access(1'b1, 24'h000204, 32'h0, 1'b1, 32'h0000_0004, '0);
    access(1'b0, 24'h000200, 32'h0000_0004, 1'b0, 32'h0, 16'h0004);
    access(1'b1, 24'h000200, 32'h0, 1'b1, 32'h0000_0004, '0);
    check("irq_set_wins", 32'(o_irq), 32'd1);
    access(1'b0, 24'h000200, 32'h0000_0004, 1'b0, 32'h0, '0);
    access(1'b1, 24'h000200, 32'h0, 1'b1, 32'h0000_0000, '0);
    check("irq_cleared", 32'(o_irq), 32'd0);
`else
    @(negedge clk); i_irq_set = 16'hFFFF;
    repeat (3) @(negedge clk);
    i_irq_set = '0;
    check("irq_tied", 32'(o_irq), 32'd0);
    access(1'b1, 24'h000200, 32'h0, 1'b1, UNMAPPED_RDATA, '0);
    access(1'b0, 24'h000204, 32'h0000_FFFF, 1'b0, 32'h0, '0);
    access(1'b1, 24'h000204, 32'h0, 1'b1, UNMAPPED_RDATA, '0);
    check("irq_tied_end", 32'(o_irq), 32'd0);
`endif

    // reset during ACCESS of a write to ctrl[0]
    @(negedge clk);
    cmd_if.sel = 1'b1; cmd_if.rd_wr_n = 1'b0; cmd_if.byte_addr = 24'h000000; cmd_if.wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    cmd_if.sel = 1'b0; arst = 1'b1;
    #1;
    check("abort_ack", 32'(cmd_if.ack), 32'd0);
    check("abort_ctrl0", o_ctrl[0], 32'd0);
    check("abort_ctrl1_rst", o_ctrl[1], 32'd0);
    @(negedge clk);
    arst = 1'b0;
    begin
      int acks = 0;
      repeat (3) begin
        @(negedge clk);
        if (cmd_if.ack === 1'b1) acks++;
      end
      check("abort_no_ack", 32'(acks), 32'd0);
    end
    check("abort_ctrl0_after", o_ctrl[0], 32'd0);
    access(1'b1, 24'h000000, 32'h0, 1'b1, 32'h0000_0000, '0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
